// File: rtl/axis_effect_scheduler_if.sv
// AXI-Stream link (data/valid/ready/last) shared by every stream port of the scheduler.
// Latency: none, this is wiring only.
// Backpressure: plain valid/ready; ready flows from the slave side back to the master side.
//
// Ports (modports):
//   master : drives data, valid and last; samples ready
//   slave  : samples data, valid and last; drives ready
interface axis_effect_scheduler_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;
   logic              last;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_effect_scheduler.sv
// Packet-level round-robin sharing of one AXIS effect core between two requester streams.
// Latency: one grant cycle per packet, then zero added latency; data passes through combinationally.
// Backpressure: core ready goes straight to the granted source; granted sink ready goes straight to the core.
//
// Ports:
//   clk, resetn          : clock and synchronous active-low reset
//   req_enable[1:0]      : per-requester effect enable, captured when that requester is granted
//   s0_axis, s1_axis     : requester input streams (slave)
//   m0_axis, m1_axis     : processed output streams back to each requester (master)
//   c_m_axis             : stream into the effect core (master)
//   c_s_axis             : stream out of the effect core (slave)
//   core_enable          : effect enable for the core, constant for the whole packet
//   grant                : requester currently owning the core, or the last owner
//   busy                 : a packet is in flight
//   timeout_err          : one-cycle pulse when a stuck packet is abandoned
//   pkt_count0/1         : completed packets per requester, wrapping
module axis_effect_scheduler #(
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 4096,
   parameter int CNT_W       = 16
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [1:0]              req_enable,
   axis_effect_scheduler_if.slave  s0_axis,
   axis_effect_scheduler_if.slave  s1_axis,
   axis_effect_scheduler_if.master m0_axis,
   axis_effect_scheduler_if.master m1_axis,
   axis_effect_scheduler_if.master c_m_axis,
   axis_effect_scheduler_if.slave  c_s_axis,
   output logic                    core_enable,
   output logic                    grant,
   output logic                    busy,
   output logic                    timeout_err,
   output logic [CNT_W-1:0]        pkt_count0,
   output logic [CNT_W-1:0]        pkt_count1
);

   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FWD,
      ST_DRAIN
   } state_t;

   state_t            state;
   logic              last_grant;
   logic              in_done;
   logic              out_done;
   logic [WD_W-1:0]   wd_cnt;

   logic              in_act;
   logic              out_act;
   logic              pick;
   logic              in_hs_last;
   logic              out_hs;
   logic              out_hs_last;
   logic              in_done_nxt;
   logic              out_done_nxt;
   logic [WD_W-1:0]   wd_nxt;
   logic              wd_expire;

   assign busy = (state != ST_IDLE);

   // Each side of the routing switches off independently once its packet has
   // seen its last beat, so a finished side cannot leak a beat of the next packet.
   assign in_act  = busy && !in_done;
   assign out_act = busy && !out_done;

   // Round-robin only matters on contention; a lone requester always wins.
   assign pick = (s0_axis.valid && s1_axis.valid) ? ~last_grant : s1_axis.valid;

   always_comb begin
      c_m_axis.data  = '0;
      c_m_axis.valid = 1'b0;
      c_m_axis.last  = 1'b0;
      s0_axis.ready  = 1'b0;
      s1_axis.ready  = 1'b0;
      m0_axis.data   = '0;
      m0_axis.valid  = 1'b0;
      m0_axis.last   = 1'b0;
      m1_axis.data   = '0;
      m1_axis.valid  = 1'b0;
      m1_axis.last   = 1'b0;
      c_s_axis.ready = 1'b0;

      if (in_act) begin
         if (grant) begin
            c_m_axis.data  = s1_axis.data;
            c_m_axis.valid = s1_axis.valid;
            c_m_axis.last  = s1_axis.last;
            s1_axis.ready  = c_m_axis.ready;
         end else begin
            c_m_axis.data  = s0_axis.data;
            c_m_axis.valid = s0_axis.valid;
            c_m_axis.last  = s0_axis.last;
            s0_axis.ready  = c_m_axis.ready;
         end
      end

      if (out_act) begin
         if (grant) begin
            m1_axis.data   = c_s_axis.data;
            m1_axis.valid  = c_s_axis.valid;
            m1_axis.last   = c_s_axis.last;
            c_s_axis.ready = m1_axis.ready;
         end else begin
            m0_axis.data   = c_s_axis.data;
            m0_axis.valid  = c_s_axis.valid;
            m0_axis.last   = c_s_axis.last;
            c_s_axis.ready = m0_axis.ready;
         end
      end
   end

   assign in_hs_last   = c_m_axis.valid && c_m_axis.ready && c_m_axis.last;
   assign out_hs       = c_s_axis.valid && c_s_axis.ready;
   assign out_hs_last  = out_hs && c_s_axis.last;
   assign in_done_nxt  = in_done  || in_hs_last;
   assign out_done_nxt = out_done || out_hs_last;

   // Watchdog measures silence on the core output only; input stalls count too,
   // since a core that never answers looks the same either way.
   assign wd_nxt    = out_hs ? '0 : wd_cnt + WD_W'(1);
   assign wd_expire = (wd_nxt == WD_W'(TIMEOUT_CYC));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         last_grant  <= 1'b1;
         grant       <= 1'b0;
         core_enable <= 1'b0;
         in_done     <= 1'b0;
         out_done    <= 1'b0;
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
         pkt_count0  <= '0;
         pkt_count1  <= '0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               in_done  <= 1'b0;
               out_done <= 1'b0;
               // Grant cycle: no beat moves until routing is live next cycle.
               if (s0_axis.valid || s1_axis.valid) begin
                  grant       <= pick;
                  core_enable <= req_enable[pick];
                  wd_cnt      <= '0;
                  state       <= ST_FWD;
               end
            end

            ST_FWD, ST_DRAIN: begin
               in_done  <= in_done_nxt;
               out_done <= out_done_nxt;
               wd_cnt   <= wd_nxt;
               if (in_done_nxt && out_done_nxt) begin
                  // Completion may land in FWD when the core emits its last
                  // beat together with the input last.
                  state      <= ST_IDLE;
                  last_grant <= grant;
                  in_done    <= 1'b0;
                  out_done   <= 1'b0;
                  if (grant) begin
                     pkt_count1 <= pkt_count1 + CNT_W'(1);
                  end else begin
                     pkt_count0 <= pkt_count0 + CNT_W'(1);
                  end
               end else if (wd_expire) begin
                  // Abandoned packet is not counted, but still rotates the
                  // priority so a wedged requester cannot starve the other.
                  state       <= ST_IDLE;
                  last_grant  <= grant;
                  timeout_err <= 1'b1;
                  in_done     <= 1'b0;
                  out_done    <= 1'b0;
               end else if (in_done_nxt) begin
                  state <= ST_DRAIN;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_effect_scheduler.sv
// Randomized bench for axis_effect_scheduler with a queue-based reference model.
// Latency: n/a (testbench).
// Backpressure: bench drives random source valid, core ready/valid and sink ready.
module tb_axis_effect_scheduler;
   localparam int DW = 32;
   localparam int TO = 16;
   localparam int CW = 16;
   localparam logic [DW-1:0] MASK = 32'hA5A5_0000;

   logic           clk = 1'b0;
   logic           resetn;
   logic [1:0]     req_enable;
   logic           core_enable;
   logic           grant;
   logic           busy;
   logic           timeout_err;
   logic [CW-1:0]  pkt_count0;
   logic [CW-1:0]  pkt_count1;

   axis_effect_scheduler_if #(.DATA_W(DW)) s0_if ();
   axis_effect_scheduler_if #(.DATA_W(DW)) s1_if ();
   axis_effect_scheduler_if #(.DATA_W(DW)) m0_if ();
   axis_effect_scheduler_if #(.DATA_W(DW)) m1_if ();
   axis_effect_scheduler_if #(.DATA_W(DW)) cm_if ();
   axis_effect_scheduler_if #(.DATA_W(DW)) cs_if ();

   axis_effect_scheduler #(.DATA_W(DW), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .req_enable  (req_enable),
      .s0_axis     (s0_if),
      .s1_axis     (s1_if),
      .m0_axis     (m0_if),
      .m1_axis     (m1_if),
      .c_m_axis    (cm_if),
      .c_s_axis    (cs_if),
      .core_enable (core_enable),
      .grant       (grant),
      .busy        (busy),
      .timeout_err (timeout_err),
      .pkt_count0  (pkt_count0),
      .pkt_count1  (pkt_count1)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Reference model state: words are {last, data}.
   logic [DW:0] sq [2][$];   // words still to be offered by each source
   logic [DW:0] eq [2][$];   // words each sink must still receive
   logic [DW:0] cq [$];      // words held inside the core model
   int          mcnt [2];
   logic [1:0]  exp_en;
   logic        mlast, exp_g, cur_g, en_lat, out_open, exp_to, prev_busy;
   logic        s_vld [2];
   logic        m_rdy [2];
   logic        cs_vld, tog;
   bit          src_rand, core_rand, m_rand, m_toggle, core_stall;
   int          run, to_seen, busy_len;
   int          glog [$];

   function automatic logic [DW:0] head_of(input int i);
      if (sq[i].size() == 0) return '0;
      return sq[i][0];
   endfunction

   task automatic push_pkt(input int i, input int len);
      for (int k = 0; k < len; k++) sq[i].push_back({(k == len - 1), DW'($urandom())});
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         sq[i].delete(); eq[i].delete();
         mcnt[i] = 0; s_vld[i] = 1'b0; m_rdy[i] = 1'b1;
      end
      cq.delete(); glog.delete();
      mlast = 1'b1; exp_g = 1'b0; cur_g = 1'b0; en_lat = 1'b0; out_open = 1'b0;
      exp_to = 1'b0; prev_busy = 1'b0; cs_vld = 1'b0; tog = 1'b0; run = 0; busy_len = 0;
   endtask

   task automatic drive();
      for (int i = 0; i < 2; i++) begin
         if (sq[i].size() == 0) s_vld[i] = 1'b0;
         else if (!s_vld[i]) s_vld[i] = !src_rand || ($urandom_range(0, 3) != 0);
         if (m_toggle) m_rdy[i] = (i == 0) ? !tog : 1'b1;
         else m_rdy[i] = !m_rand || ($urandom_range(0, 3) != 0);
      end
      tog = !tog;
      s0_if.valid = s_vld[0];
      {s0_if.last, s0_if.data} = head_of(0);
      s1_if.valid = s_vld[1];
      {s1_if.last, s1_if.data} = head_of(1);
      cm_if.ready = !core_rand || ($urandom_range(0, 3) != 0);
      if (cq.size() == 0 || core_stall) cs_vld = 1'b0;
      else if (!cs_vld) cs_vld = !core_rand || ($urandom_range(0, 3) != 0);
      cs_if.valid = cs_vld;
      {cs_if.last, cs_if.data} = (cq.size() != 0) ? cq[0] : '0;
      m0_if.ready = m_rdy[0];
      m1_if.ready = m_rdy[1];
   endtask

   task automatic observe();
      logic [DW:0] w;
      logic [1:0]  s_rdy_o;
      logic [1:0]  m_vld_o;
      logic [DW:0] m_word [2];
      bit          hs_cs;
      s_rdy_o   = {s1_if.ready, s0_if.ready};
      m_vld_o   = {m1_if.valid, m0_if.valid};
      m_word[0] = {m0_if.last, m0_if.data};
      m_word[1] = {m1_if.last, m1_if.data};
      hs_cs     = 1'b0;

      check_eq("timeout_err", timeout_err, exp_to);
      if (timeout_err) begin
         to_seen++;
         mlast = cur_g; cq.delete(); eq[cur_g].delete(); cs_vld = 1'b0; out_open = 1'b0;
      end

      if (busy && !prev_busy) begin
         check_eq("grant", grant, exp_g);
         check_eq("core_enable_at_grant", core_enable, exp_en[exp_g]);
         cur_g = exp_g; en_lat = exp_en[exp_g]; out_open = 1'b1; run = 0; busy_len = 0;
         glog.push_back(int'(grant));
      end

      if (!busy) begin
         check_eq("idle_quiet", {s_rdy_o, m_vld_o, cm_if.valid, cs_if.ready}, 0);
      end else begin
         busy_len++;
         check_eq("nongrant_quiet", cur_g ? {s0_if.ready, m0_if.valid} : {s1_if.ready, m1_if.valid}, 0);
         check_eq("grant_hold", {grant, core_enable}, {cur_g, en_lat});
         if (out_open) check_eq("cs_ready_mirror", cs_if.ready, m_rdy[cur_g]);
         if (cm_if.valid) check_eq("cm_passthru", {cm_if.last, cm_if.data}, head_of(int'(cur_g)));
      end

      // Handshakes visible now complete at the coming clock edge.
      for (int i = 0; i < 2; i++) begin
         if (s_vld[i] && s_rdy_o[i]) begin
            w = sq[i].pop_front();
            eq[i].push_back({w[DW], w[DW-1:0] ^ (en_lat ? MASK : '0)});
            s_vld[i] = 1'b0;
         end
      end
      if (cs_vld && cs_if.ready) begin
         w = cq.pop_front();
         cs_vld = 1'b0;
         hs_cs = 1'b1;
      end
      if (cm_if.valid && cm_if.ready) cq.push_back({cm_if.last, cm_if.data ^ (core_enable ? MASK : '0)});
      for (int i = 0; i < 2; i++) begin
         if (m_vld_o[i] && m_rdy[i]) begin
            check_eq($sformatf("m%0d_pending", i), (eq[i].size() != 0), 1);
            if (eq[i].size() != 0) begin
               w = eq[i].pop_front();
               check_eq($sformatf("m%0d_word", i), m_word[i], w);
               if (w[DW]) begin
                  mcnt[i]++; mlast = (i == 1); out_open = 1'b0;
               end
            end
         end
      end

      // Watchdog: abort after TO consecutive edges in flight without a core-output beat.
      if (busy) begin
         run = hs_cs ? 0 : run + 1;
         exp_to = (run >= TO);
      end else begin
         run = 0;
         exp_to = 1'b0;
      end

      if (!busy && (s_vld[0] || s_vld[1]))
         exp_g = (s_vld[0] && s_vld[1]) ? !mlast : s_vld[1];
      prev_busy = busy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      observe();
   endtask

   task automatic run_until_idle(input int maxc);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (!done && n < maxc) begin
         step();
         n++;
         done = !busy && sq[0].size() == 0 && sq[1].size() == 0 && cq.size() == 0
                && eq[0].size() == 0 && eq[1].size() == 0;
      end
      check_eq("drain_done", done, 1);
   endtask

   task automatic check_counts();
      check_eq("pkt_count0", pkt_count0, CW'(mcnt[0]));
      check_eq("pkt_count1", pkt_count1, CW'(mcnt[1]));
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      model_reset();
      drive();
      @(negedge clk);
      check_eq("rst_outputs", {s1_if.ready, s0_if.ready, m1_if.valid, m0_if.valid, cm_if.valid,
                               cs_if.ready, busy, timeout_err, grant, core_enable}, 0);
      check_eq("rst_count0", pkt_count0, 0);
      check_eq("rst_count1", pkt_count1, 0);
      observe();
   endtask

   initial begin
      int n;
      resetn = 1'b0; req_enable = 2'b00; exp_en = 2'b00;
      src_rand = 0; core_rand = 0; m_rand = 0; m_toggle = 0; core_stall = 0; to_seen = 0;
      model_reset();
      drive();
      pulse_reset();

      // Single requester on s0 with its effect enabled.
      req_enable = 2'b01; exp_en = 2'b01;
      push_pkt(0, 4);
      run_until_idle(200);
      check_counts();
      check_eq("single_grant_count", glog.size(), 1);

      // Fairness under continuous contention.
      glog.delete();
      req_enable = 2'b11; exp_en = 2'b11;
      for (int k = 0; k < 3; k++) begin
         push_pkt(0, 2 + k);
         push_pkt(1, 3);
      end
      run_until_idle(400);
      check_eq("fair_grants", glog.size(), 6);
      for (int k = 1; k < glog.size(); k++) check_eq("fair_alternate", glog[k], glog[k-1] ^ 1);
      check_counts();

      // Randomized traffic with random stalls everywhere.
      src_rand = 1; core_rand = 1; m_rand = 1;
      repeat (4) begin
         req_enable = 2'($urandom_range(0, 3));
         exp_en = req_enable;
         repeat (3) begin
            push_pkt(0, $urandom_range(1, 6));
            push_pkt(1, $urandom_range(1, 6));
         end
         run_until_idle(2000);
         check_counts();
      end

      // Sink backpressure toggling every cycle on m0.
      src_rand = 0; core_rand = 0; m_rand = 0; m_toggle = 1;
      req_enable = 2'b01; exp_en = 2'b01;
      push_pkt(0, 6);
      run_until_idle(200);
      m_toggle = 0;
      check_counts();

      // Enable changes mid-packet take effect only at the next grant.
      core_rand = 1;
      req_enable = 2'b10; exp_en = 2'b10;
      push_pkt(1, 8);
      n = 0;
      while (sq[1].size() > 4 && n < 100) begin step(); n++; end
      check_eq("latch_midpacket_busy", busy, 1);
      req_enable = 2'b00;
      run_until_idle(300);
      exp_en = 2'b00;
      push_pkt(1, 3);
      run_until_idle(200);
      check_counts();

      // Watchdog: core swallows the packet and never answers.
      core_rand = 0; core_stall = 1;
      req_enable = 2'b11; exp_en = 2'b11;
      glog.delete(); to_seen = 0;
      push_pkt(0, 4);
      n = 0;
      while (!busy && n < 20) begin step(); n++; end
      push_pkt(1, 2);
      push_pkt(0, 2);
      n = 0;
      while (to_seen == 0 && n < 100) begin step(); n++; end
      check_eq("wd_pulse_seen", to_seen, 1);
      check_eq("wd_busy_cycles", busy_len, TO);
      core_stall = 0;
      run_until_idle(300);
      check_eq("wd_single_pulse", to_seen, 1);
      check_eq("wd_grants", glog.size(), 3);
      if (glog.size() > 1) check_eq("wd_next_grant", glog[1], 1);
      check_counts();

      // Reset while a packet sits in DRAIN.
      core_stall = 1;
      push_pkt(0, 3);
      n = 0;
      while (!(busy && sq[0].size() == 0) && n < 50) begin step(); n++; end
      step();
      step();
      check_eq("pre_reset_busy", busy, 1);
      pulse_reset();
      core_stall = 0;
      push_pkt(0, 2);
      push_pkt(1, 2);
      run_until_idle(200);
      check_eq("post_reset_first_grant", (glog.size() > 0) ? glog[0] : -1, 0);
      check_counts();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
